// File: rtl/plot_writer_pkg.sv
// Shared display constants and the plot writer state encoding.
package plot_writer_pkg;

  localparam int unsigned SCR_W     = 160;
  localparam int unsigned SCR_H     = 120;
  localparam int unsigned PIX_COUNT = SCR_W * SCR_H;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 7;
  localparam int unsigned COLOUR_W  = 3;

  typedef enum logic {
    StNormal = 1'b0,
    StClear  = 1'b1
  } state_e;

  // y*160 + x without a multiplier: 160 = 128 + 32.
  function automatic logic [ADDR_W-1:0] pix_addr_160(logic [Y_W-1:0] y, logic [X_W-1:0] x);
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] x_ext;
    y_ext = {{(ADDR_W - Y_W){1'b0}}, y};
    x_ext = {{(ADDR_W - X_W){1'b0}}, x};
    return (y_ext << 7) + (y_ext << 5) + x_ext;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/plot_writer.sv
// Pixel-plot queue in front of a framebuffer write port, with a full-screen clear engine.
module plot_writer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SCR_W = 160,
  parameter int unsigned SCR_H = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        plot_in,
  input  logic [7:0]  x_in,
  input  logic [6:0]  y_in,
  input  logic [2:0]  colour_in,
  input  logic        clear_start,
  input  logic [2:0]  clear_colour,
  input  logic        fb_ready,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_colour,
  output logic        full,
  output logic        empty,
  output logic        clearing,
  output logic        clear_done,
  output logic [7:0]  drop_count,
  output logic        range_err
);

  import plot_writer_pkg::*;

  localparam int unsigned EntryW = ADDR_W + COLOUR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(SCR_W * SCR_H - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic [COLOUR_W-1:0] clr_colour_q;
  logic                clear_done_q;
  logic [7:0]          drop_count_q;
  logic                range_err_q;

  logic [ADDR_W-1:0]   in_addr;
  logic                in_range;
  logic                push, pop, drop;
  logic [EntryW-1:0]   head;
  logic                fifo_full, fifo_empty;

  // Linear address of the incoming request.
  if (SCR_W == 160) begin : g_addr_shift
    assign in_addr = pix_addr_160(y_in, x_in);
  end else begin : g_addr_mul
    assign in_addr = ADDR_W'(32'(y_in) * SCR_W + 32'(x_in));
  end

  assign in_range = (32'(x_in) < SCR_W) && (32'(y_in) < SCR_H);
  assign pop      = (state_q == StNormal) & ~fifo_empty & fb_ready;
  assign push     = plot_in & in_range & (~fifo_full | pop);
  assign drop     = plot_in & in_range & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_addr, colour_in}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NORMAL drains the queue; CLEAR sweeps every pixel while the queue keeps filling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StNormal;
      clr_addr_q   <= '0;
      clr_colour_q <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      unique case (state_q)
        StNormal: begin
          if (clear_start) begin
            state_q      <= StClear;
            clr_addr_q   <= '0;
            clr_colour_q <= clear_colour;
          end
        end
        StClear: begin
          if (fb_ready) begin
            if (clr_addr_q == LastAddr) begin
              state_q      <= StNormal;
              clr_addr_q   <= '0;
              clear_done_q <= 1'b1;
            end else begin
              clr_addr_q <= clr_addr_q + 1'b1;
            end
          end
        end
        default: state_q <= StNormal;
      endcase
    end
  end

  // Overflow counter saturates; range error is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
      range_err_q  <= 1'b0;
    end else begin
      if (drop && (drop_count_q != 8'hFF)) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
      if (plot_in && !in_range) begin
        range_err_q <= 1'b1;
      end
    end
  end

  // Write port mux: clear engine owns the port while clearing, otherwise the queue head.
  always_comb begin
    fb_we     = ~fifo_empty;
    fb_addr   = head[EntryW-1:COLOUR_W];
    fb_colour = head[COLOUR_W-1:0];
    if (state_q == StClear) begin
      fb_we     = 1'b1;
      fb_addr   = clr_addr_q;
      fb_colour = clr_colour_q;
    end
  end

  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign clearing   = (state_q == StClear);
  assign clear_done = clear_done_q;
  assign drop_count = drop_count_q;
  assign range_err  = range_err_q;

endmodule

// File: tb/tb_plot_writer.sv
// Scoreboard bench for plot_writer: expected framebuffer writes are queued as stimulus is applied.
module tb_plot_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        plot_in;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [2:0]  colour_in;
  logic        clear_start;
  logic [2:0]  clear_colour;
  logic        fb_ready;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_colour;
  logic        full, empty, clearing, clear_done;
  logic [7:0]  drop_count;
  logic        range_err;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  col;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  wr_count = 0;
  int  done_count = 0;

  always #5 clk = ~clk;

  plot_writer #(
    .DEPTH (8),
    .SCR_W (160),
    .SCR_H (120)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .plot_in      (plot_in),
    .x_in         (x_in),
    .y_in         (y_in),
    .colour_in    (colour_in),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .fb_ready     (fb_ready),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_colour    (fb_colour),
    .full         (full),
    .empty        (empty),
    .clearing     (clearing),
    .clear_done   (clear_done),
    .drop_count   (drop_count),
    .range_err    (range_err)
  );

  // Every accepted framebuffer write must match the head of the expected queue.
  always @(negedge clk) begin
    if (clear_done) done_count++;
    if (!rst && fb_we && fb_ready) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: addr=%0d colour=%0d, expected no write", fb_addr, fb_colour);
      end else begin
        mon_e = exp_q.pop_front();
        if (fb_addr !== mon_e.addr || fb_colour !== mon_e.col) begin
          errors++;
          $display("FAIL wr_data: addr=%0d colour=%0d, expected addr=%0d colour=%0d",
                   fb_addr, fb_colour, mon_e.addr, mon_e.col);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int addr, input int col);
    wr_t w;
    w.addr = 15'(addr);
    w.col  = 3'(col);
    exp_q.push_back(w);
  endtask

  task automatic plot(input int x, input int y, input int c);
    x_in      = 8'(x);
    y_in      = 7'(y);
    colour_in = 3'(c);
    plot_in   = 1'b1;
    tick();
    plot_in   = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && empty && !clearing) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: %0d writes outstanding, expected 0", name, exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fb_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %b, expected 0", fb_we); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, expected 0", full); end
    checks++; if (clearing !== 1'b0) begin errors++; $display("FAIL reset_clearing: got %b, expected 0", clearing); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done: got %b, expected 0", clear_done); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d, expected 0", drop_count); end
    checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err: got %b, expected 0", range_err); end
    tick();
  endtask

  task automatic test_single();
    fb_ready = 1'b1;
    push_exp(3 * 160 + 5, 4);
    plot(5, 3, 4);
    @(negedge clk);
    checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b, expected 1", fb_we); end
    checks++; if (fb_addr !== 15'd485) begin errors++; $display("FAIL single_addr: got %0d, expected 485", fb_addr); end
    checks++; if (fb_colour !== 3'd4) begin errors++; $display("FAIL single_colour: got %0d, expected 4", fb_colour); end
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b, expected 1", empty); end
    tick();
  endtask

  task automatic test_overflow();
    int occ = 0;
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (occ < 8) begin
        push_exp((1 + i) * 160 + 10 + i, i % 8);
        occ++;
      end
      plot(10 + i, 1 + i, i % 8);
    end
    @(negedge clk);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b, expected 1", full); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drop: got %0d, expected 2", drop_count); end
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd170 || fb_colour !== 3'd0) begin
      errors++;
      $display("FAIL ovf_hold: we=%b addr=%0d colour=%0d, expected we=1 addr=170 colour=0",
               fb_we, fb_addr, fb_colour);
    end
    tick();
    fb_ready = 1'b1;
    wait_drain(50, "ovf");
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drop_after: got %0d, expected 2", drop_count); end
  endtask

  task automatic test_range();
    fb_ready = 1'b1;
    plot(160, 0, 1);
    plot(0, 120, 2);
    @(negedge clk);
    checks++; if (empty !== 1'b1 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL range_queued: empty=%b we=%b, expected empty=1 we=0", empty, fb_we);
    end
    checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_err_set: got %b, expected 1", range_err); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL range_drop: got %0d, expected 2", drop_count); end
    tick();
    push_exp(19199, 7);
    plot(159, 119, 7);
    @(negedge clk);
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd19199) begin
      errors++;
      $display("FAIL range_corner: we=%b addr=%0d, expected we=1 addr=19199", fb_we, fb_addr);
    end
    checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_err_sticky: got %b, expected 1", range_err); end
    tick();
    wait_drain(20, "range");
  endtask

  task automatic test_clear();
    int w0 = wr_count;
    int d0 = done_count;
    fb_ready = 1'b1;
    for (int a = 0; a < 19200; a++) push_exp(a, 0);
    clear_colour = 3'd0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    clear_colour = 3'd3;
    @(negedge clk);
    checks++; if (clearing !== 1'b1) begin errors++; $display("FAIL clear_enter: got %b, expected 1", clearing); end
    tick();
    repeat (100) tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    push_exp(161, 5);
    plot(1, 1, 5);
    wait_drain(20000, "clear");
    checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL clear_done_cnt: got %0d, expected 1", done_count - d0); end
    checks++; if (wr_count - w0 !== 19201) begin errors++; $display("FAIL clear_writes: got %0d, expected 19201", wr_count - w0); end
  endtask

  task automatic test_clear_toggle();
    int w0 = wr_count;
    int d0 = done_count;
    logic [14:0] last = '0;
    bit have = 1'b0;
    bit ok = 1'b0;
    fb_ready = 1'b0;
    plot(2, 0, 1);
    plot(3, 0, 2);
    clear_colour = 3'd6;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int a = 0; a < 19200; a++) push_exp(a, 6);
    push_exp(2, 1);
    push_exp(3, 2);
    @(negedge clk);
    checks++; if (clearing !== 1'b1 || fb_we !== 1'b1 || fb_addr !== 15'd0 || fb_colour !== 3'd6) begin
      errors++;
      $display("FAIL tog_start: clearing=%b we=%b addr=%0d colour=%0d, expected 1 1 0 6",
               clearing, fb_we, fb_addr, fb_colour);
    end
    tick();
    for (int i = 0; i < 45000; i++) begin
      fb_ready = (i % 2 == 0);
      @(negedge clk);
      if (clearing) begin
        if (have && fb_ready) begin
          checks++;
          if (fb_addr !== last) begin
            errors++;
            $display("FAIL tog_hold: addr=%0d, expected %0d", fb_addr, last);
          end
        end
        last = fb_addr;
        have = !fb_ready;
      end else begin
        have = 1'b0;
      end
      if (exp_q.size() == 0 && empty && !clearing) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    fb_ready = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL tog_drain: %0d writes outstanding, expected 0", exp_q.size()); end
    checks++; if (wr_count - w0 !== 19202) begin errors++; $display("FAIL tog_writes: got %0d, expected 19202", wr_count - w0); end
    checks++; if (done_count - d0 !== 1) begin errors++; $display("FAIL tog_done_cnt: got %0d, expected 1", done_count - d0); end
  endtask

  task automatic test_reset_clear();
    int w0 = wr_count;
    int d0 = done_count;
    bit ok = 1'b0;
    fb_ready = 1'b1;
    for (int a = 0; a < 500; a++) push_exp(a, 2);
    clear_colour = 3'd2;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    plot(4, 4, 3);
    plot(5, 5, 3);
    for (int i = 0; i < 1000; i++) begin
      if (wr_count - w0 >= 500) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL rstclr_reach: got %0d writes, expected 500", wr_count - w0); end
    checks++; if (clearing !== 1'b0) begin errors++; $display("FAIL rstclr_clearing: got %b, expected 0", clearing); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rstclr_we: got %b, expected 0", fb_we); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstclr_empty: got %b, expected 1", empty); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL rstclr_done: got %b, expected 0", clear_done); end
    checks++; if (drop_count !== 8'd0 || range_err !== 1'b0) begin
      errors++;
      $display("FAIL rstclr_counters: drop=%0d range_err=%b, expected 0 0", drop_count, range_err);
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rstclr_pending: got %0d, expected 0", exp_q.size()); end
    tick();
    repeat (20) tick();
    checks++; if (done_count - d0 !== 0) begin errors++; $display("FAIL rstclr_no_done: got %0d, expected 0", done_count - d0); end
    checks++; if (wr_count - w0 !== 500) begin errors++; $display("FAIL rstclr_writes: got %0d, expected 500", wr_count - w0); end
  endtask

  initial begin
    rst = 1'b1;
    plot_in = 1'b0;
    x_in = '0;
    y_in = '0;
    colour_in = '0;
    clear_start = 1'b0;
    clear_colour = '0;
    fb_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_range();
    test_clear();
    test_clear_toggle();
    test_reset_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plot_writer.md
PLOT_WRITER -- requirements
Module: plot_writer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of FIFO entries (power of two, 2..32).
REQ-002 The block SHALL have parameter SCR_W, default 160, giving the screen width in pixels.
REQ-003 The block SHALL have parameter SCR_H, default 120, giving the screen height in pixels.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port plot_in, input, 1 bit: pixel-write request from the game backend.
REQ-007 The block SHALL have port x_in, input, 8 bits: pixel column.
REQ-008 The block SHALL have port y_in, input, 7 bits: pixel row.
REQ-009 The block SHALL have port colour_in, input, 3 bits: pixel colour.
REQ-010 The block SHALL have port clear_start, input, 1 bit: pulse that starts a full-screen clear.
REQ-011 The block SHALL have port clear_colour, input, 3 bits: fill colour, sampled on the accepted clear_start.
REQ-012 The block SHALL have port fb_ready, input, 1 bit: framebuffer accepts a write this cycle.
REQ-013 The block SHALL have port fb_we, output, 1 bit: framebuffer write valid.
REQ-014 The block SHALL have port fb_addr, output, 15 bits: linear address y*SCR_W+x.
REQ-015 The block SHALL have port fb_colour, output, 3 bits: write data.
REQ-016 The block SHALL have port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-017 The block SHALL have port empty, output, 1 bit: FIFO holds 0 entries.
REQ-018 The block SHALL have port clearing, output, 1 bit: FSM is in CLEAR.
REQ-019 The block SHALL have port clear_done, output, 1 bit: one-cycle pulse at the end of a clear.
REQ-020 The block SHALL have port drop_count, output, 8 bits: number of requests lost to overflow, saturating.
REQ-021 The block SHALL have port range_err, output, 1 bit: sticky flag set by an out-of-range request.

Function
REQ-022 The block SHALL compute the address at input as (y<<7)+(y<<5)+x when SCR_W=160, and SHALL store the address and colour in the FIFO.
REQ-023 The block SHALL discard a plot_in with x_in>=SCR_W or y_in>=SCR_H, SHALL set range_err, and SHALL NOT count it in drop_count.
REQ-024 The block SHALL push an in-range plot_in when the FIFO is not full, or when it is full and a pop occurs in the same cycle; the occupancy then stays unchanged.
REQ-025 In all other full cases the block SHALL drop the request and increment drop_count, holding drop_count at 255.
REQ-026 The FSM SHALL have two states, NORMAL and CLEAR, and SHALL reset to NORMAL.
REQ-027 In NORMAL the FIFO output SHALL be show-ahead: fb_we=!empty, with fb_addr/fb_colour taken from the head entry.
REQ-028 In NORMAL the block SHALL pop the head on any cycle where fb_we and fb_ready are both high.
REQ-029 A request pushed into an empty FIFO at edge N SHALL present fb_we=1 in the cycle following edge N (1-cycle latency).
REQ-030 While fb_ready=0, fb_we, fb_addr and fb_colour SHALL hold stable.
REQ-031 In NORMAL, clear_start SHALL move the FSM to CLEAR at the next edge, load clr_addr=0, and latch clear_colour.
REQ-032 clear_start SHALL take effect even if the FIFO is non-empty; the FIFO contents are retained.
REQ-033 In CLEAR the block SHALL drive fb_we=1, fb_addr=clr_addr and fb_colour=the latched colour; it SHALL pop no FIFO entries but SHALL keep accepting pushes.
REQ-034 In CLEAR, clr_addr SHALL increment only when fb_ready=1.
REQ-035 When clr_addr=SCR_W*SCR_H-1 (19199) is written with fb_ready=1, the FSM SHALL return to NORMAL and clear_done SHALL be high for exactly the following cycle.
REQ-036 clear_start SHALL be ignored while in CLEAR.
REQ-037 After CLEAR, buffered plots SHALL drain in FIFO order, so every pixel queued during a clear lands on top of the cleared screen.

Reset
REQ-038 With rst=1 at an edge, the block SHALL clear the FIFO pointers and count, set the FSM to NORMAL, set clr_addr=0, drop_count=0 and range_err=0.
REQ-039 On the cycle after reset, the outputs SHALL be fb_we=0, empty=1, full=0, clearing=0 and clear_done=0.
REQ-040 Reset during CLEAR SHALL abort the clear without asserting clear_done.
REQ-041 Reset SHALL discard any queued entries.

Structure
REQ-042 SCR_W, SCR_H, PIX_COUNT=19200 and ADDR_W=15 SHALL be defined in a shared display constants package.
REQ-043 The NORMAL/CLEAR state encoding SHALL be defined in that shared package.
REQ-044 The FIFO SHALL be a sub-module named sync_fifo (parameterised by width and depth, with full/empty/push/pop); the FSM, the address computation and the counters SHALL reside in plot_writer.

Verification
REQ-045 The bench SHALL apply plot x=5,y=3,colour=4 with fb_ready=1 and check fb_we=1, fb_addr=485, fb_colour=4 in the next cycle, then empty=1.
REQ-046 The bench SHALL hold fb_ready=0, push 10 plots with DEPTH=8, and check full=1, drop_count=2; on releasing fb_ready, the 8 entries SHALL emerge in order.
REQ-047 The bench SHALL apply plot x=160,y=0 and check that nothing is queued and range_err=1 stays set; then x=159,y=119 SHALL give fb_addr=19199.
REQ-048 The bench SHALL apply clear_start with colour 0 and fb_ready=1, and check 19200 writes at addresses 0..19199 and clear_done pulsed once; a plot injected mid-clear SHALL be written afterwards.
REQ-049 The bench SHALL toggle fb_ready every other cycle during a clear and check that clr_addr advances only on ready cycles and the total write count is 19200.
REQ-050 The bench SHALL assert rst after 500 clear writes and check clearing=0, no clear_done, empty=1 and fb_we=0.
